rx_fifo_ctrl: RTL and testbench
===============================

// Module: rx_fifo_ctrl
// PURPOSE
//  Receive-side buffer that sits directly downstream of rx. It accepts each byte from
//  rx (rx_po, rx_ready, rx_error) and returns the rx_data_ack handshake. Good bytes go
//  into a small FIFO. The oldest byte is presented on head_data for the led_disp pair.
//  A user pop strobe advances the FIFO. Errored frames are counted, never stored.
// PARAMETERS
//  DEPTH  4  FIFO entries; power of two, >=2
//  AW     2  pointer width, log2(DEPTH)
//  ERR_W  4  width of saturating frame-error counter
// PORTS
//  clk        in   1      single clock; all logic on posedge
//  rst_n      in   1      reset, asynchronous, active-low
//  en         in   1      global enable; 0 freezes all state and outputs
//  rx_ready   in   1      rx has a frame on rx_po; held until acked
//  rx_error   in   1      frame on rx_po failed framing/parity; valid with rx_ready
//  rx_po      in   8      received byte
//  rx_data_ack out 1      acknowledge to rx (4-phase, registered)
//  pop        in   1      user advance request, synchronous level; rising edge acts
//  clear      in   1      synchronous flush of FIFO, overflow flag and error counter
//  head_data  out  8      oldest stored byte; 8'h00 when empty
//  count      out  AW+1   bytes stored, 0..DEPTH
//  empty      out  1      count==0
//  full       out  1      count==DEPTH
//  overflow   out  1      sticky: a good byte was dropped because FIFO was full
//  err_cnt    out  ERR_W  saturating count of frames received with rx_error=1
// BEHAVIOUR
//  Reset (rst_n=0, async): FSM=IDLE, rx_data_ack=0, rd/wr ptr=0, count=0, empty=1,
//   full=0, overflow=0, err_cnt=0, head_data=8'h00, pop edge register=0. RAM is not reset.
//  en=0: no state changes at all. rx_data_ack holds its value. pop edge history holds.
//  Handshake FSM, 2 states:
//   IDLE: on a clk edge with rx_ready=1, take one frame in that same edge:
//    - rx_error=1: err_cnt+1, saturating at all-ones. Byte is discarded.
//    - rx_error=0, write allowed: mem[wr_ptr]<=rx_po, wr_ptr+1 (wraps mod DEPTH).
//    - rx_error=0, write not allowed: byte dropped, overflow<=1.
//    In all three cases rx_data_ack<=1 and the FSM goes to ACK.
//   ACK: rx_data_ack stays 1 while rx_ready=1. On the edge with rx_ready=0,
//    rx_data_ack<=0 and the FSM goes to IDLE. One frame is taken per ready pulse.
//  Latency: byte is visible in count/head_data on the edge after capture. Ack rises
//   on the capture edge, so rx sees ack 1 cycle after ready is sampled.
//  Pop: pop_q is the registered pop. pop_edge = pop & ~pop_q.
//   - pop_edge with empty=1 is ignored. No underflow; pointers are unchanged.
//   - otherwise rd_ptr+1 (wraps mod DEPTH).
//  Write allowed = !full || pop_edge. A write and a pop in the same edge both happen,
//   including when full. count is then unchanged and overflow is not set.
//  count is updated as +1 (write only), -1 (pop only), or unchanged.
//   full/empty are derived from count, never from pointer compare.
//  head_data = empty ? 8'h00 : mem[rd_ptr]. This is combinational from the registers.
//  clear=1 (with en=1): ptrs=0, count=0, overflow=0, err_cnt=0 on that edge.
//   It has priority over write and pop in the same edge.
//   The FSM/ack is unaffected, so an in-flight frame still completes its handshake.
//   A frame captured in the same edge as clear is discarded.
//  rst_n asserted mid-handshake: ack drops immediately (async). After release, a
//   still-high rx_ready is treated as a new frame.
// TESTING
//  T1 reset: rst_n=0 with any inputs -> ack=0, count=0, empty=1, head_data=8'h00, err_cnt=0
//  T2 single byte: rx_po=8'hAA, ready 1 until ack, then 0 -> ack 1 cycle after ready,
//     drops 1 cycle after ready falls; count=1, head_data=8'hAA; pop edge -> empty=1
//  T3 fill+overflow: send 77,AA,A9,10,EF -> full=1 after 4th; 5th acked, dropped,
//     overflow=1; pops yield 77,AA,A9,10 in order, then wrap and write again correctly
//  T4 errors: 17 frames with rx_error=1 -> every one acked, count stays 0, err_cnt=4'hF
//     (saturates); clear=1 -> err_cnt=0, overflow=0
//  T5 simultaneous: FIFO full, pop rising in same edge as capture of 8'h55 -> count
//     stays 4, overflow stays 0, head=2nd-oldest, 8'h55 is the last popped
//  T6 en/pop: hold pop high 5 cycles -> exactly one pop; en=0 during handshake -> ack
//     and count frozen until en=1, then the handshake completes normally

Source files
------------

// File: rtl/rx_fifo_ctrl_if.sv
// rx_fifo_ctrl_if
//   Bundles the receive handshake from rx, the user pop/clear controls and the
//   FIFO status outputs of rx_fifo_ctrl.
//   master : the rx frame source and the user side (drives rx_*, pop, clear)
//   slave  : rx_fifo_ctrl (drives rx_data_ack, head_data, count, flags, err_cnt)
interface rx_fifo_ctrl_if #(
  parameter int AW    = 2,
  parameter int ERR_W = 4
);
  logic             rx_ready;
  logic             rx_error;
  logic [7:0]       rx_po;
  logic             rx_data_ack;
  logic             pop;
  logic             clear;
  logic [7:0]       head_data;
  logic [AW:0]      count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output rx_ready, rx_error, rx_po, pop, clear,
    input  rx_data_ack, head_data, count, empty, full, overflow, err_cnt
  );

  modport slave (
    input  rx_ready, rx_error, rx_po, pop, clear,
    output rx_data_ack, head_data, count, empty, full, overflow, err_cnt
  );
endinterface

// File: rtl/rx_fifo_ctrl.sv
// rx_fifo_ctrl
//   Receive-side buffer behind rx. Each frame is taken once per rx_ready pulse
//   and acknowledged with a registered 4-phase rx_data_ack. Good bytes are
//   queued in a DEPTH-entry FIFO, errored frames only bump a saturating counter.
//   The oldest byte is shown on head_data; a rising edge on pop advances it.
// Ports
//   clk   : single clock, posedge
//   rst_n : asynchronous active-low reset
//   en    : global enable, 0 freezes every register
//   bus   : rx_fifo_ctrl_if.slave (handshake, pop/clear, status)
//
// state  | meaning
// S_IDLE | waiting for rx_ready; a frame is captured on the edge it is seen
// S_ACK  | frame taken, ack held high until rx_ready falls
module rx_fifo_ctrl #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int ERR_W = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  rx_fifo_ctrl_if.slave bus
);

  typedef enum logic {S_IDLE, S_ACK} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_ack, w_ack_nxt;
  logic             r_pop_q;
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_ovf;
  logic [ERR_W-1:0] r_err_cnt;
  logic [7:0]       r_mem [DEPTH];

  logic w_take, w_empty, w_full, w_pop_edge, w_pop_do;
  logic w_wr_ok, w_wr_do, w_drop, w_err;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == (AW+1)'(DEPTH));
  assign w_take     = (r_state == S_IDLE) && bus.rx_ready;
  assign w_pop_edge = bus.pop & ~r_pop_q;
  assign w_pop_do   = w_pop_edge & ~w_empty;
  // A pop on the same edge frees a slot, so a full FIFO still accepts the byte.
  assign w_wr_ok    = ~w_full | w_pop_edge;
  assign w_wr_do    = w_take & ~bus.rx_error & w_wr_ok;
  assign w_drop     = w_take & ~bus.rx_error & ~w_wr_ok;
  assign w_err      = w_take & bus.rx_error;

  always_comb begin
    w_state_nxt = r_state;
    w_ack_nxt   = r_ack;
    case (r_state)
      S_IDLE: if (bus.rx_ready) begin
        w_state_nxt = S_ACK;
        w_ack_nxt   = 1'b1;
      end
      S_ACK: if (!bus.rx_ready) begin
        w_state_nxt = S_IDLE;
        w_ack_nxt   = 1'b0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_ack_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ack   <= 1'b0;
    end else if (en) begin
      r_state <= w_state_nxt;
      r_ack   <= w_ack_nxt;
    end
  end

  // Clear flushes the FIFO side only; the handshake above keeps running so an
  // in-flight frame still completes, but whatever it carried is discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pop_q   <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
      r_err_cnt <= '0;
    end else if (en) begin
      r_pop_q <= bus.pop;
      if (bus.clear) begin
        r_wr_ptr  <= '0;
        r_rd_ptr  <= '0;
        r_count   <= '0;
        r_ovf     <= 1'b0;
        r_err_cnt <= '0;
      end else begin
        if (w_wr_do)  r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop_do) r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_wr_do, w_pop_do})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
        if (w_drop) r_ovf <= 1'b1;
        if (w_err && !(&r_err_cnt)) r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (en && !bus.clear && w_wr_do) r_mem[r_wr_ptr] <= bus.rx_po;
  end

  assign bus.rx_data_ack = r_ack;
  assign bus.head_data   = w_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign bus.count       = r_count;
  assign bus.empty       = w_empty;
  assign bus.full        = w_full;
  assign bus.overflow    = r_ovf;
  assign bus.err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_rx_fifo_ctrl.sv
module tb_rx_fifo_ctrl;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en    = 1'b1;

  rx_fifo_ctrl_if #(.AW(2), .ERR_W(4)) bus ();

  rx_fifo_ctrl #(.DEPTH(4), .AW(2), .ERR_W(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];
  logic       exp_ovf = 1'b0;
  int         exp_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    logic [7:0] exp_head;
    exp_head = (exp_q.size() == 0) ? 8'h00 : exp_q[0];
    check({tag, "_count"}, 32'(bus.count), 32'(exp_q.size()));
    check({tag, "_head"},  32'(bus.head_data), 32'(exp_head));
    check({tag, "_empty"}, 32'(bus.empty), 32'(exp_q.size() == 0));
    check({tag, "_full"},  32'(bus.full), 32'(exp_q.size() == 4));
    check({tag, "_ovf"},   32'(bus.overflow), 32'(exp_ovf));
    check({tag, "_err"},   32'(bus.err_cnt), 32'(exp_err));
  endtask

  // One full 4-phase handshake; ack must rise one edge after ready and fall
  // one edge after ready drops.
  task automatic send(input string tag, input logic [7:0] b, input logic err);
    bus.rx_po    = b;
    bus.rx_error = err;
    bus.rx_ready = 1'b1;
    tick();
    check({tag, "_ack_rise"}, 32'(bus.rx_data_ack), 32'd1);
    if (err) begin
      if (exp_err < 15) exp_err++;
    end else if (exp_q.size() < 4) exp_q.push_back(b);
    else exp_ovf = 1'b1;
    bus.rx_ready = 1'b0;
    bus.rx_error = 1'b0;
    tick();
    check({tag, "_ack_fall"}, 32'(bus.rx_data_ack), 32'd0);
    check_state(tag);
  endtask

  task automatic pop_one(input string tag);
    check({tag, "_pophead"}, 32'(bus.head_data), 32'(exp_q[0]));
    bus.pop = 1'b1;
    tick();
    void'(exp_q.pop_front());
    bus.pop = 1'b0;
    tick();
    check_state(tag);
  endtask

  initial begin
    bus.rx_ready = 1'b1;
    bus.rx_error = 1'b0;
    bus.rx_po    = 8'h3C;
    bus.pop      = 1'b1;
    bus.clear    = 1'b0;

    // T1: reset with active inputs
    #23;
    check("rst_ack", 32'(bus.rx_data_ack), 32'd0);
    check_state("rst");
    bus.rx_ready = 1'b0;
    bus.pop      = 1'b0;
    #10 rst_n = 1'b1;
    tick();

    // T2: single byte
    send("t2", 8'hAA, 1'b0);
    pop_one("t2pop");

    // T3: fill, overflow, drain in order, then wrap
    send("t3a", 8'h77, 1'b0);
    send("t3b", 8'hAA, 1'b0);
    send("t3c", 8'hA9, 1'b0);
    send("t3d", 8'h10, 1'b0);
    send("t3ovf", 8'hEF, 1'b0);
    for (int i = 0; i < 4; i++) pop_one("t3pop");
    send("t3w1", 8'h21, 1'b0);
    send("t3w2", 8'h32, 1'b0);
    send("t3w3", 8'h43, 1'b0);
    for (int i = 0; i < 3; i++) pop_one("t3wpop");

    // T4: errored frames saturate the counter, clear resets flags
    for (int i = 0; i < 17; i++) send("t4err", 8'(i), 1'b1);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    exp_err = 0;
    exp_ovf = 1'b0;
    check_state("t4clr");

    // T5: full FIFO, capture and pop rising on the same edge
    send("t5a", 8'h01, 1'b0);
    send("t5b", 8'h02, 1'b0);
    send("t5c", 8'h03, 1'b0);
    send("t5d", 8'h04, 1'b0);
    check("t5_head0", 32'(bus.head_data), 32'h01);
    bus.rx_po    = 8'h55;
    bus.rx_ready = 1'b1;
    bus.pop      = 1'b1;
    tick();
    check("t5_ack", 32'(bus.rx_data_ack), 32'd1);
    void'(exp_q.pop_front());
    exp_q.push_back(8'h55);
    check_state("t5sim");
    bus.rx_ready = 1'b0;
    bus.pop      = 1'b0;
    tick();
    check("t5_ackfall", 32'(bus.rx_data_ack), 32'd0);
    for (int i = 0; i < 4; i++) pop_one("t5pop");

    // T6: held pop gives exactly one pop
    send("t6a", 8'hB1, 1'b0);
    send("t6b", 8'hB2, 1'b0);
    bus.pop = 1'b1;
    repeat (5) tick();
    bus.pop = 1'b0;
    tick();
    void'(exp_q.pop_front());
    check_state("t6hold");

    // T6: en=0 freezes the handshake at both phases
    bus.rx_po    = 8'hC3;
    bus.rx_ready = 1'b1;
    en           = 1'b0;
    repeat (3) tick();
    check("t6_frz_ack0", 32'(bus.rx_data_ack), 32'd0);
    check_state("t6frz0");
    en = 1'b1;
    tick();
    check("t6_ack1", 32'(bus.rx_data_ack), 32'd1);
    exp_q.push_back(8'hC3);
    bus.rx_ready = 1'b0;
    en           = 1'b0;
    repeat (2) tick();
    check("t6_frz_ack1", 32'(bus.rx_data_ack), 32'd1);
    check_state("t6frz1");
    en = 1'b1;
    tick();
    check("t6_ack_fall", 32'(bus.rx_data_ack), 32'd0);
    check_state("t6done");

    // Reset mid-handshake, ready still high afterwards starts a new frame
    bus.rx_po    = 8'h5A;
    bus.rx_ready = 1'b1;
    tick();
    check("rstm_ack1", 32'(bus.rx_data_ack), 32'd1);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_ovf = 1'b0;
    exp_err = 0;
    check("rstm_ack0", 32'(bus.rx_data_ack), 32'd0);
    check_state("rstm");
    #2 rst_n = 1'b1;
    tick();
    check("rstm_new_ack", 32'(bus.rx_data_ack), 32'd1);
    exp_q.push_back(8'h5A);
    bus.rx_ready = 1'b0;
    tick();
    check("rstm_ack_fall", 32'(bus.rx_data_ack), 32'd0);
    check_state("rstm_new");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
